bpsk_modulator_top: RTL and testbench
=====================================

BPSK_MODULATOR_TOP -- requirements
Module: bpsk_modulator_top

Interface
REQ-001 Parameter WIDTH, default `FIXDT_64_A_WIDTH (16 when params.vh is absent); output sample width in bits, signed two's complement, fixed-point Q1.(WIDTH-1).
REQ-002 Parameter LUT_DEPTH, default 64; carrier samples per carrier period, power of two.
REQ-003 clk  input  1  sole clock (200 MHz nominal); all state SHALL update on its rising edge.
REQ-004 rst  input  1  synchronous, active-low reset; sampled only on rising clk.
REQ-005 en  input  1  sample enable; high = advance carrier and produce a new output sample.
REQ-006 in  input  1  data bit to modulate; 0 = carrier at phase 0, 1 = carrier at phase pi.
REQ-007 out  output  WIDTH  signed, registered modulated carrier sample.

Function
REQ-008 Design SHALL hold a phase index p of log2(LUT_DEPTH) bits and a constant sine table S[k] = round(sin(2*pi*k/LUT_DEPTH) * (2^(WIDTH-1)-1)), k = 0..LUT_DEPTH-1.
- S is symmetric; max magnitude 2^(WIDTH-1)-1, so negation never overflows.
- For WIDTH=16: S[0]=0, S[8]=23170, S[16]=32767, S[32]=0, S[48]=-32767.
REQ-009 On each rising edge with rst=1 and en=1: out <= (in ? -S[p] : S[p]); p <= (p+1) mod LUT_DEPTH.
REQ-010 Latency: in and p are sampled at the same edge; out reflects them one cycle later (one register stage, no extra pipeline).
REQ-011 Phase wraps from LUT_DEPTH-1 to 0 with no gap or repeated sample.
REQ-012 Polarity change of in takes effect on the very next enabled sample; p is NOT reset or realigned on a bit transition (continuous carrier, abrupt 180-degree flip).
REQ-013 With rst=1 and en=0: p and out SHALL hold their values; in is ignored.
REQ-014 Negation SHALL be exact two's complement of S[p] at full WIDTH; no saturation logic needed.
REQ-015 No handshake; in may change on any cycle, and its value at the enabled edge is the one used.

Reset
REQ-016 On a rising edge with rst=0: p <= 0, out <= 0, regardless of en or in.
REQ-017 Reset SHALL take priority over en at the same edge; reset asserted mid-carrier SHALL restart the next sequence at S[0].
REQ-018 First enabled edge after reset release SHALL output +/-S[0] = 0; the second SHALL output +/-S[1].

Verification
REQ-019 Hold rst=0 for 3 cycles with en=1, in=1 -> out=0 every cycle, p=0.
REQ-020 Release reset, en=1, in=0, run 64 cycles -> out sequence S[0..63] (WIDTH=16: 0 at cycle 1, 23170 at cycle 9, 32767 at cycle 17, -32767 at cycle 49), then S[0] again at cycle 65.
REQ-021 Same as REQ-020 but in=1 -> out = -S[k] each cycle (cycle 17 out = -32767).
REQ-022 in toggles every 20 cycles (100 ns at 200 MHz) for 10 toggles -> out = S[p] or -S[p] with continuous p; at each toggle, the sign inverts on the first sample after the toggle edge and the magnitude sequence stays continuous.
REQ-023 en=1 for 5 cycles, en=0 for 4 cycles, en=1 -> out holds S[4] during the low period; the next sample is S[5].
REQ-024 Assert rst=0 for one cycle at p=37 -> out=0 on the following cycle; the sequence then restarts at S[0].

Source files
------------

// File: rtl/bpsk_modulator_top.sv
`default_nettype none

`ifndef FIXDT_64_A_WIDTH
`define FIXDT_64_A_WIDTH 16
`endif

// ============================================================================
//  Module      : bpsk_modulator_top
//  Description : BPSK modulator. A phase accumulator walks a constant sine
//                table one entry per enabled cycle; the data bit selects the
//                table value or its two's complement negation. The output is
//                registered, so it follows the sampled bit and phase by one
//                cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module bpsk_modulator_top #(
  parameter int WIDTH     = `FIXDT_64_A_WIDTH,
  parameter int LUT_DEPTH = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    in,
  output logic signed [WIDTH-1:0] out
);

  // Phase index width. Keep at least one bit so a degenerate depth of 1
  // still elaborates.
  localparam int C_PW = (LUT_DEPTH > 1) ? $clog2(LUT_DEPTH) : 1;

  // Elaboration-time sine sample, rounded half away from zero to the
  // symmetric full scale of +/-(2^(WIDTH-1)-1). That full scale is what
  // lets the negation below never overflow.
  function automatic logic signed [WIDTH-1:0] sine_at(input int k);
    real c_pi;
    real amp;
    real x;
    int  sample;
    c_pi = 3.14159265358979323846;
    amp  = (2.0 ** (WIDTH - 1)) - 1.0;
    x    = $sin(2.0 * c_pi * k / LUT_DEPTH) * amp;
    if (x >= 0.0) begin
      sample = $rtoi(x + 0.5);
    end else begin
      sample = $rtoi(x - 0.5);
    end
    return sample[WIDTH-1:0];
  endfunction

  logic signed [WIDTH-1:0] w_lut [LUT_DEPTH];
  logic signed [WIDTH-1:0] w_sine;

  logic [C_PW-1:0]         phase_q;
  logic [C_PW-1:0]         phase_d;
  logic signed [WIDTH-1:0] out_q;
  logic signed [WIDTH-1:0] out_d;

  // Constant sine table, one elaboration-time entry per carrier sample.
  for (genvar k = 0; k < LUT_DEPTH; k++) begin : g_lut
    localparam logic signed [WIDTH-1:0] C_S = sine_at(k);
    assign w_lut[k] = C_S;
  end

  assign w_sine = w_lut[phase_q];

  // Next-state: advance the carrier and choose the polarity only when
  // enabled. The phase is never realigned on a data-bit change, so a bit
  // flip is an abrupt 180-degree jump on a continuous carrier.
  always_comb begin
    phase_d = phase_q;
    out_d   = out_q;
    if (en) begin
      out_d   = in ? -w_sine : w_sine;
      // Power-of-two depth: natural overflow performs the modulo wrap.
      phase_d = phase_q + C_PW'(1);
    end
  end

  // State registers with synchronous active-low reset. Reset has priority
  // over the enable.
  always_ff @(posedge clk) begin
    if (!rst) begin
      phase_q <= '0;
      out_q   <= '0;
    end else begin
      phase_q <= phase_d;
      out_q   <= out_d;
    end
  end

  assign out = out_q;

endmodule

`default_nettype wire

// File: tb/tb_bpsk_modulator_top.sv
`default_nettype none
`timescale 1ns/1ps

// ============================================================================
//  Module      : tb_bpsk_modulator_top
//  Description : Self-checking bench for bpsk_modulator_top. A behavioural
//                model (phase counter plus sine formula) predicts each
//                output sample. Directed sequences and randomized traffic
//                are both compared against it.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bpsk_modulator_top;

  localparam int WIDTH     = 16;
  localparam int LUT_DEPTH = 64;

  logic                    clk;
  logic                    rst;
  logic                    en;
  logic                    in_bit;
  logic signed [WIDTH-1:0] out;

  int total;
  int bad;

  // Reference state: phase counter and the predicted registered output.
  int m_p;
  int m_out;

  bpsk_modulator_top #(
    .WIDTH    (WIDTH),
    .LUT_DEPTH(LUT_DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .en (en),
    .in (in_bit),
    .out(out)
  );

  // 200 MHz clock.
  initial clk = 1'b0;
  always #2.5 clk = ~clk;

  // Ideal rounded sine sample, as defined for the carrier table.
  function automatic int ref_sine(input int k);
    real x;
    x = $sin(2.0 * 3.14159265358979323846 * k / LUT_DEPTH) * ((2.0 ** (WIDTH - 1)) - 1.0);
    if (x >= 0.0) return $rtoi(x + 0.5);
    return $rtoi(x - 0.5);
  endfunction

  // Counts one comparison and reports a mismatch.
  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Drives one cycle. The model is updated with the values present at the
  // rising edge, and the output is compared 1 ns after that edge.
  task automatic tick(input string tag, input logic r, input logic e, input logic b);
    rst    = r;
    en     = e;
    in_bit = b;
    @(posedge clk);
    if (!r) begin
      m_p   = 0;
      m_out = 0;
    end else if (e) begin
      m_out = b ? -ref_sine(m_p) : ref_sine(m_p);
      m_p   = (m_p + 1) % LUT_DEPTH;
    end
    #1;
    chk(tag, int'(out), m_out);
  endtask

  initial begin
    total  = 0;
    bad    = 0;
    m_p    = 0;
    m_out  = 0;
    rst    = 1'b0;
    en     = 1'b1;
    in_bit = 1'b1;

    // Reset held with en=1, in=1: output stays 0.
    for (int c = 0; c < 3; c++) begin
      tick("reset_hold", 1'b0, 1'b1, 1'b1);
      chk("reset_zero", int'(out), 0);
    end

    // Positive carrier over one full period plus the wrap.
    for (int c = 1; c <= 65; c++) begin
      tick("carrier_pos", 1'b1, 1'b1, 1'b0);
      if (c == 1)  chk("pos_c1",  int'(out), 0);
      if (c == 9)  chk("pos_c9",  int'(out), 23170);
      if (c == 17) chk("pos_c17", int'(out), 32767);
      if (c == 49) chk("pos_c49", int'(out), -32767);
      if (c == 65) chk("pos_wrap", int'(out), 0);
    end

    // Inverted carrier from a fresh reset.
    tick("reset2", 1'b0, 1'b1, 1'b0);
    for (int c = 1; c <= 65; c++) begin
      tick("carrier_neg", 1'b1, 1'b1, 1'b1);
      if (c == 9)  chk("neg_c9",  int'(out), -23170);
      if (c == 17) chk("neg_c17", int'(out), -32767);
      if (c == 49) chk("neg_c49", int'(out), 32767);
    end

    // Data bit toggling every 20 cycles, ten toggles, continuous phase.
    tick("reset3", 1'b0, 1'b0, 1'b0);
    for (int c = 0; c < 220; c++) begin
      tick("toggle", 1'b1, 1'b1, 1'((c / 20) % 2));
    end

    // Enable gap: hold S[4] while disabled, then resume with S[5].
    tick("reset4", 1'b0, 1'b1, 1'b0);
    for (int c = 0; c < 5; c++) tick("gap_run", 1'b1, 1'b1, 1'b0);
    for (int c = 0; c < 4; c++) begin
      tick("gap_hold", 1'b1, 1'b0, 1'($urandom_range(0, 1)));
      chk("gap_s4", int'(out), ref_sine(4));
    end
    tick("gap_resume", 1'b1, 1'b1, 1'b0);
    chk("gap_s5", int'(out), ref_sine(5));

    // Reset mid-carrier at phase 37, then restart from S[0].
    tick("reset5", 1'b0, 1'b1, 1'b0);
    for (int c = 0; c < 37; c++) tick("mid_run", 1'b1, 1'b1, 1'b0);
    tick("mid_reset", 1'b0, 1'b1, 1'b1);
    chk("mid_zero", int'(out), 0);
    tick("mid_restart0", 1'b1, 1'b1, 1'b0);
    chk("mid_s0", int'(out), 0);
    tick("mid_restart1", 1'b1, 1'b1, 1'b0);
    chk("mid_s1", int'(out), ref_sine(1));

    // Randomized enable, data and occasional reset.
    for (int c = 0; c < 600; c++) begin
      tick("random",
           ($urandom_range(0, 49) != 0),
           1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
